// File: rtl/alu_core_if.sv
//============================================================================
// Module      : alu_core_if
// Description : Operand/opcode/result/status bundle for alu_core.
//               master drives operands and load enable; slave (the ALU)
//               drives the result, zero flag and registered status.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

interface alu_core_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] Ain;
    logic [WIDTH-1:0] Bin;
    logic [1:0]       ALUop;
    logic             load_s;
    logic [WIDTH-1:0] out;
    logic             Z;
    logic [2:0]       status;

    modport master (
        output Ain,
        output Bin,
        output ALUop,
        output load_s,
        input  out,
        input  Z,
        input  status
    );

    modport slave (
        input  Ain,
        input  Bin,
        input  ALUop,
        input  load_s,
        output out,
        output Z,
        output status
    );
endinterface

`default_nettype wire

// File: rtl/alu_core.sv
//============================================================================
// Module      : alu_core
// Description : Combinational ADD/SUB/AND/NOT unit with zero flag and a
//               clocked {V,N,Z} status register.
//               Optional macro ALU_EXT_FLAGS_EN: when defined, signed
//               overflow (V) and negative (N) are captured in status[2:1];
//               when undefined only Z is registered and status[2:1] = 0.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module alu_core #(
    parameter int WIDTH = 16
) (
    input  wire logic clk,
    input  wire logic reset,
    alu_core_if.slave bus
);

    localparam logic [1:0] C_OP_ADD = 2'b00;
    localparam logic [1:0] C_OP_SUB = 2'b01;
    localparam logic [1:0] C_OP_AND = 2'b10;
    localparam logic [1:0] C_OP_NOT = 2'b11;

    logic [WIDTH-1:0] w_result;
    logic             w_zero;

    // Result selection; carry and borrow are simply dropped by the width.
    always_comb begin
        w_result = '0;
        case (bus.ALUop)
            C_OP_ADD: w_result = bus.Ain + bus.Bin;
            C_OP_SUB: w_result = bus.Ain - bus.Bin;
            C_OP_AND: w_result = bus.Ain & bus.Bin;
            C_OP_NOT: w_result = ~bus.Bin;
            default:  w_result = '0;
        endcase
    end

    assign w_zero  = (w_result == '0);
    assign bus.out = w_result;
    assign bus.Z   = w_zero;

`ifdef ALU_EXT_FLAGS_EN
    logic       w_a_msb;
    logic       w_b_msb;
    logic       w_r_msb;
    logic       w_ovf;
    logic [2:0] status_q;
    logic [2:0] status_d;

    assign w_a_msb = bus.Ain[WIDTH-1];
    assign w_b_msb = bus.Bin[WIDTH-1];
    assign w_r_msb = w_result[WIDTH-1];

    // Signed overflow: operand signs agree (ADD) or disagree (SUB) and the
    // result sign flips away from operand A. Logic ops never overflow.
    always_comb begin
        w_ovf = 1'b0;
        case (bus.ALUop)
            C_OP_ADD: w_ovf = (w_a_msb == w_b_msb) && (w_r_msb != w_a_msb);
            C_OP_SUB: w_ovf = (w_a_msb != w_b_msb) && (w_r_msb != w_a_msb);
            default:  w_ovf = 1'b0;
        endcase
    end

    // Next status: capture {V,N,Z} on load, otherwise hold.
    always_comb begin
        status_d = status_q;
        if (bus.load_s) begin
            status_d = {w_ovf, w_r_msb, w_zero};
        end
    end

    // Status register, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            status_q <= 3'b000;
        end else begin
            status_q <= status_d;
        end
    end

    assign bus.status = status_q;
`else
    logic z_q;
    logic z_d;

    // Next zero-flag: capture on load, otherwise hold.
    always_comb begin
        z_d = z_q;
        if (bus.load_s) begin
            z_d = w_zero;
        end
    end

    // Zero-flag register, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            z_q <= 1'b0;
        end else begin
            z_q <= z_d;
        end
    end

    assign bus.status = {2'b00, z_q};
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_core.sv
//============================================================================
// Module      : tb_alu_core
// Description : Self-checking bench for alu_core: directed vector table
//               plus hold and asynchronous-reset sequences.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_alu_core;

    localparam int WIDTH = 16;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
        logic [15:0] exp_out;
        logic        exp_z;
        logic        exp_v;
        logic        exp_n;
    } vec_t;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_fail;
    vec_t vecs[14];

    alu_core_if #(.WIDTH(WIDTH)) bus ();

    alu_core #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] exp_status(input logic v, input logic n, input logic z);
`ifdef ALU_EXT_FLAGS_EN
        return {v, n, z};
`else
        return {2'b00, z};
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] op, input logic ld);
        bus.Ain    = a;
        bus.Bin    = b;
        bus.ALUop  = op;
        bus.load_s = ld;
    endtask

    initial begin
        n_vec  = 0;
        n_fail = 0;

        vecs[0]  = '{16'h000D, 16'h0006, 2'b00, 16'h0013, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{16'h000D, 16'h0006, 2'b01, 16'h0007, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{16'h000D, 16'h0006, 2'b10, 16'h0004, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{16'h000D, 16'h0006, 2'b11, 16'hFFF9, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{16'h1234, 16'hFFFF, 2'b11, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{16'h0005, 16'h0005, 2'b01, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{16'h7FFF, 16'h0001, 2'b00, 16'h8000, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{16'hFFFF, 16'h0001, 2'b00, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{16'h8000, 16'h0001, 2'b01, 16'h7FFF, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{16'h8000, 16'h8000, 2'b00, 16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{16'h0000, 16'h0001, 2'b01, 16'hFFFF, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{16'hF0F0, 16'hFF00, 2'b10, 16'hF000, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{16'h7FFF, 16'hFFFF, 2'b01, 16'h8000, 1'b0, 1'b1, 1'b1};
        vecs[13] = '{16'hAAAA, 16'h0000, 2'b11, 16'hFFFF, 1'b0, 1'b0, 1'b1};

        // Reset state; combinational path must work while reset is high.
        reset = 1'b1;
        drive(16'h000D, 16'h0006, 2'b00, 1'b1);
        #1;
        check("reset_status", {29'd0, bus.status}, 32'd0);
        check("reset_out",    {16'd0, bus.out},    32'h0013);
        @(posedge clk);
        #1;
        check("reset_status_edge", {29'd0, bus.status}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Table: combinational check before the edge, status after it.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(vecs[i].a, vecs[i].b, vecs[i].op, 1'b1);
            #1;
            check($sformatf("v%0d_out", i), {16'd0, bus.out}, {16'd0, vecs[i].exp_out});
            check($sformatf("v%0d_z", i),   {31'd0, bus.Z},   {31'd0, vecs[i].exp_z});
            @(posedge clk);
            #1;
            check($sformatf("v%0d_status", i), {29'd0, bus.status},
                  {29'd0, exp_status(vecs[i].exp_v, vecs[i].exp_n, vecs[i].exp_z)});
        end

        // Hold: load a nonzero result (status Z=0), then hold while out=0.
        @(negedge clk);
        drive(16'h000D, 16'h0006, 2'b00, 1'b1);
        @(posedge clk);
        #1;
        check("hold_pre", {29'd0, bus.status}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(16'h0005 + 16'(k), 16'h0005 + 16'(k), 2'b01, 1'b0);
            #1;
            check($sformatf("hold%0d_z", k), {31'd0, bus.Z}, 32'd1);
            @(posedge clk);
            #1;
            check($sformatf("hold%0d_status", k), {29'd0, bus.status}, 32'd0);
        end
        @(negedge clk);
        bus.load_s = 1'b1;
        @(posedge clk);
        #1;
        check("hold_reload", {29'd0, bus.status}, 32'd1);

        // Asynchronous reset between edges clears a nonzero status at once.
        @(negedge clk);
        drive(16'h7FFF, 16'h0001, 2'b00, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_status", {29'd0, bus.status}, 32'd0);
        check("async_reset_out",    {16'd0, bus.out},    32'h8000);

        // Load while in reset is ignored; out/Z keep tracking.
        drive(16'h0005, 16'h0005, 2'b01, 1'b1);
        #1;
        check("in_reset_z", {31'd0, bus.Z}, 32'd1);
        @(posedge clk);
        #1;
        check("in_reset_load", {29'd0, bus.status}, 32'd0);

        // Release and confirm capture works again.
        @(negedge clk);
        reset = 1'b0;
        drive(16'h7FFF, 16'h0001, 2'b00, 1'b1);
        @(posedge clk);
        #1;
        check("post_reset_load", {29'd0, bus.status}, {29'd0, exp_status(1'b1, 1'b1, 1'b0)});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
